// File: rtl/predict_update_ctrl.sv
// Write-port controller for the branch prediction cache: queues resolved
// branches, updates their 2-bit control bits and runs a full-cache flush.
module predict_update_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LINE_BITS  = 7
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Upd_Valid,
  output logic        Upd_Ready,
  input  logic [31:0] Upd_PC,
  input  logic [31:0] Upd_Target,
  input  logic        Upd_Taken,
  input  logic        Upd_Hit,
  input  logic [1:0]  Upd_OldCB,
  input  logic        Flush_Req,
  output logic        Flush_Busy,
  output logic        Cache_WE,
  output logic [31:0] Cache_WAddr,
  output logic [31:0] Cache_Data,
  output logic [1:0]  Cache_CB
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [31:0]    q_pc  [FIFO_DEPTH];
  logic [31:0]    q_tgt [FIFO_DEPTH];
  logic [1:0]     q_cb  [FIFO_DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic [LINE_BITS-1:0] idx;

  logic fifo_empty, fifo_full;
  logic accept, keep, push, pop, flush_start, last_idx;
  logic [1:0] new_cb;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  assign Upd_Ready   = (state == IDLE) && !fifo_full;
  assign accept      = Upd_Valid && Upd_Ready;
  assign keep        = Upd_Hit || Upd_Taken;
  assign flush_start = (state == IDLE) && Flush_Req;
  assign push        = accept && keep && !Flush_Req;
  assign pop         = (state == IDLE) && !fifo_empty && !Flush_Req;
  assign last_idx    = (idx == '1);

  // Saturating 2-bit counter; a first-time taken branch enters weakly taken.
  always_comb begin
    new_cb = 2'b10;
    if (Upd_Hit) begin
      if (Upd_Taken)
        new_cb = (Upd_OldCB == 2'b11) ? 2'b11 : Upd_OldCB + 2'b01;
      else
        new_cb = (Upd_OldCB == 2'b00) ? 2'b00 : Upd_OldCB - 2'b01;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Flush_Req) state_nxt = FLUSH;
      FLUSH:   if (last_idx)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      q_pc[wptr[AW-1:0]]  <= Upd_PC;
      q_tgt[wptr[AW-1:0]] <= Upd_Target;
      q_cb[wptr[AW-1:0]]  <= new_cb;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush_start) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  // Address/data/CB hold their last value whenever no write is issued.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Cache_WE    <= 1'b0;
      Cache_WAddr <= '0;
      Cache_Data  <= '0;
      Cache_CB    <= '0;
      Flush_Busy  <= 1'b0;
      idx         <= '0;
    end else begin
      Flush_Busy <= (state_nxt == FLUSH);
      if (state == FLUSH) begin
        Cache_WE    <= 1'b1;
        Cache_WAddr <= {{(32-LINE_BITS){1'b0}}, idx};
        Cache_Data  <= '0;
        Cache_CB    <= 2'b00;
        idx         <= last_idx ? '0 : idx + LINE_BITS'(1);
      end else if (pop) begin
        Cache_WE    <= 1'b1;
        Cache_WAddr <= q_pc[rptr[AW-1:0]];
        Cache_Data  <= q_tgt[rptr[AW-1:0]];
        Cache_CB    <= q_cb[rptr[AW-1:0]];
      end else begin
        Cache_WE    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_predict_update_ctrl.sv
// Directed bench for predict_update_ctrl: filter, CB update, streaming,
// flush sweep and reset during flush.
module tb_predict_update_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Upd_Valid = 1'b0;
  logic        Upd_Ready;
  logic [31:0] Upd_PC = '0;
  logic [31:0] Upd_Target = '0;
  logic        Upd_Taken = 1'b0;
  logic        Upd_Hit = 1'b0;
  logic [1:0]  Upd_OldCB = '0;
  logic        Flush_Req = 1'b0;
  logic        Flush_Busy;
  logic        Cache_WE;
  logic [31:0] Cache_WAddr;
  logic [31:0] Cache_Data;
  logic [1:0]  Cache_CB;

  int unsigned checks = 0;
  int unsigned errors = 0;

  predict_update_ctrl #(.FIFO_DEPTH(4), .LINE_BITS(7)) dut (
    .Clk(Clk), .Rst(Rst),
    .Upd_Valid(Upd_Valid), .Upd_Ready(Upd_Ready),
    .Upd_PC(Upd_PC), .Upd_Target(Upd_Target),
    .Upd_Taken(Upd_Taken), .Upd_Hit(Upd_Hit), .Upd_OldCB(Upd_OldCB),
    .Flush_Req(Flush_Req), .Flush_Busy(Flush_Busy),
    .Cache_WE(Cache_WE), .Cache_WAddr(Cache_WAddr),
    .Cache_Data(Cache_Data), .Cache_CB(Cache_CB)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic hit, input logic taken, input logic [1:0] ocb,
                       input logic [31:0] pc, input logic [31:0] tgt);
    Upd_Valid = 1'b1; Upd_Hit = hit; Upd_Taken = taken; Upd_OldCB = ocb;
    Upd_PC = pc; Upd_Target = tgt;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] t3_ocb [4];
    logic       t3_tkn [4];
    logic [1:0] t3_exp [4];
    int unsigned busy_cnt;
    int unsigned stale;
    t3_ocb = '{2'b11, 2'b00, 2'b01, 2'b10};
    t3_tkn = '{1'b1, 1'b0, 1'b1, 1'b0};
    t3_exp = '{2'b11, 2'b00, 2'b10, 2'b01};

    // Reset state
    #2 Rst = 1'b0;
    #1;
    check("rst_we",    Cache_WE, 0);
    check("rst_waddr", Cache_WAddr, 0);
    check("rst_data",  Cache_Data, 0);
    check("rst_cb",    Cache_CB, 0);
    check("rst_busy",  Flush_Busy, 0);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    check("rst_ready", Upd_Ready, 1);

    // 1: miss+taken enters as weakly taken, one cycle after acceptance
    drive(1'b0, 1'b1, 2'b00, 32'h40, 32'h100);
    cyc();
    Upd_Valid = 1'b0;
    check("t1_we_lat", Cache_WE, 0);
    cyc();
    check("t1_we",    Cache_WE, 1);
    check("t1_waddr", Cache_WAddr, 32'h40);
    check("t1_data",  Cache_Data, 32'h100);
    check("t1_cb",    Cache_CB, 2'b10);
    cyc();
    check("t1_we_off",  Cache_WE, 0);
    check("t1_hold_wa", Cache_WAddr, 32'h40);

    // 2: miss+not-taken is accepted and dropped
    drive(1'b0, 1'b0, 2'b00, 32'h44, 32'h144);
    check("t2_ready", Upd_Ready, 1);
    cyc();
    Upd_Valid = 1'b0;
    check("t2_we0", Cache_WE, 0);
    cyc();
    check("t2_we1",   Cache_WE, 0);
    check("t2_ready2", Upd_Ready, 1);
    check("t2_hold",  Cache_WAddr, 32'h40);

    // 3: saturating counter on hits, back to back
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) drive(1'b1, t3_tkn[i], t3_ocb[i], 32'h80 + 32'(4*i), 32'h200 + 32'(i));
      else Upd_Valid = 1'b0;
      cyc();
      if (i > 0) begin
        check("t3_we",    Cache_WE, 1);
        check("t3_waddr", Cache_WAddr, 32'h80 + 32'(4*(i-1)));
        check("t3_cb",    Cache_CB, t3_exp[i-1]);
      end
    end
    cyc();
    check("t3_we_off", Cache_WE, 0);

    // 4: sustained stream, one write per cycle in order
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        drive(1'b0, 1'b1, 2'b00, 32'h1000 + 32'(4*i), 32'h2000 + 32'(i));
        check("t4_ready", Upd_Ready, 1);
      end else Upd_Valid = 1'b0;
      cyc();
      if (i == 0) check("t4_we_lat", Cache_WE, 0);
      else begin
        check("t4_we",    Cache_WE, 1);
        check("t4_waddr", Cache_WAddr, 32'h1000 + 32'(4*(i-1)));
        check("t4_data",  Cache_Data, 32'h2000 + 32'(i-1));
      end
    end
    cyc();
    check("t4_we_off", Cache_WE, 0);

    // 4b: flush with a queued entry and a concurrent push; neither is written
    drive(1'b0, 1'b1, 2'b00, 32'h3000, 32'hABCD);
    cyc();
    drive(1'b0, 1'b1, 2'b00, 32'h3004, 32'hBCDE);
    Flush_Req = 1'b1;
    cyc();
    Upd_Valid = 1'b0;
    Flush_Req = 1'b0;
    check("t4b_we_supp", Cache_WE, 0);
    check("t4b_busy",    Flush_Busy, 1);
    check("t4b_ready",   Upd_Ready, 0);
    stale = 0;
    for (int i = 0; i < 132; i++) begin
      cyc();
      if (Cache_WE && (Cache_Data != 0 || Cache_WAddr >= 32'h3000)) stale++;
    end
    check("t4b_stale", stale, 0);
    check("t4b_idle_we", Cache_WE, 0);

    // 5: full flush sweep; second request mid-flush is ignored
    Flush_Req = 1'b1;
    cyc();
    Flush_Req = 1'b0;
    check("t5_busy0", Flush_Busy, 1);
    check("t5_we0",   Cache_WE, 0);
    busy_cnt = 1;
    for (int i = 0; i < 128; i++) begin
      if (i == 49) Flush_Req = 1'b1;
      cyc();
      Flush_Req = 1'b0;
      check("t5_we",    Cache_WE, 1);
      check("t5_waddr", Cache_WAddr, 32'(i));
      check("t5_data",  Cache_Data, 0);
      check("t5_cb",    Cache_CB, 0);
      if (i == 10) check("t5_ready", Upd_Ready, 0);
      if (Flush_Busy) busy_cnt++;
    end
    check("t5_busy_cnt", busy_cnt, 128);
    cyc();
    check("t5_we_end",  Cache_WE, 0);
    check("t5_busy_end", Flush_Busy, 0);
    check("t5_ready_end", Upd_Ready, 1);

    // 6: async reset at flush index 60
    Flush_Req = 1'b1;
    cyc();
    Flush_Req = 1'b0;
    for (int i = 0; i <= 60; i++) cyc();
    check("t6_idx60", Cache_WAddr, 32'd60);
    #2 Rst = 1'b0;
    #1;
    check("t6_we",    Cache_WE, 0);
    check("t6_waddr", Cache_WAddr, 0);
    check("t6_data",  Cache_Data, 0);
    check("t6_cb",    Cache_CB, 0);
    check("t6_busy",  Flush_Busy, 0);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    check("t6_ready", Upd_Ready, 1);
    cyc();
    check("t6_we_idle",  Cache_WE, 0);
    check("t6_busy_idle", Flush_Busy, 0);
    drive(1'b1, 1'b1, 2'b01, 32'h500, 32'h600);
    cyc();
    Upd_Valid = 1'b0;
    cyc();
    check("t6_post_we",   Cache_WE, 1);
    check("t6_post_addr", Cache_WAddr, 32'h500);
    check("t6_post_cb",   Cache_CB, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
